// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation control path: FSM states and
// motion-vector width derivation from the search-window size.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DRAIN   = 2'd3
  } me_state_e;

  function automatic int vec_width(input int sw_length);
    return $clog2(sw_length + 1);
  endfunction

  // Packed {y,x}; each component drops the sign-extension bit of VEC_WIDTH.
  function automatic int mvec_width(input int sw_length);
    return (vec_width(sw_length) - 1) * 2;
  endfunction

endpackage

// File: rtl/me_result_slot.sv
// One-entry valid/ready result register. A load always wins over an accept in
// the same cycle; the initiator never loads while the slot is full.
module me_result_slot #(
  parameter int SAD_WIDTH = 16,
  parameter int MVEC_W    = 12,
  parameter int BLK_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic [MVEC_W-1:0]    mvec_in,
  input  logic [BLK_WIDTH-1:0] idx_in,
  input  logic                 last_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [SAD_WIDTH-1:0] sad,
  output logic [MVEC_W-1:0]    mvec,
  output logic [BLK_WIDTH-1:0] idx,
  output logic                 last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sad   <= '0;
      mvec  <= '0;
      idx   <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      sad   <= sad_in;
      mvec  <= mvec_in;
      idx   <= idx_in;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/me_req_initiator.sv
// Host-side initiator for the ME core req/ack 4-phase handshake: walks the
// blocks of a frame, captures each result and hands it to a 1-entry stream.
//
// Handshakes: req/ack is 4-phase (req rises, ack rises, req falls, ack falls);
// res_valid/res_ready transfers on a cycle with both high, res_valid never
// drops and res_* never change until that transfer.
module me_req_initiator
  import me_pkg::*;
#(
  parameter int SAD_WIDTH      = 16,
  parameter int SW_LENGTH      = 64,
  parameter int BLK_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [BLK_WIDTH-1:0]               num_blocks,
  input  logic [SAD_WIDTH-1:0]               thr_cfg,
  output logic                               req,
  output logic [SAD_WIDTH-1:0]               threshold,
  output logic [BLK_WIDTH-1:0]               blk_idx,
  input  logic                               ack,
  input  logic [SAD_WIDTH-1:0]               min_sad,
  input  logic [mvec_width(SW_LENGTH)-1:0]   min_mvec,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [SAD_WIDTH-1:0]               res_sad,
  output logic [mvec_width(SW_LENGTH)-1:0]   res_mvec,
  output logic [BLK_WIDTH-1:0]               res_idx,
  output logic                               res_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [1:0]                         state_dbg
);

  localparam int MVEC_W = mvec_width(SW_LENGTH);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  me_state_e            state;
  logic [BLK_WIDTH-1:0] num_q;
  logic [TO_W-1:0]      to_cnt;
  logic                 capture;
  logic                 is_last;
  logic                 slot_free;
  logic                 start_ok;

  assign capture   = (state == ST_ISSUE) && ack;
  assign is_last   = (blk_idx == num_q - BLK_WIDTH'(1));
  assign slot_free = !res_valid || res_ready;
  // done is still high on the first IDLE cycle; a start there is dropped.
  assign start_ok  = start && (state == ST_IDLE) && !done;
  assign state_dbg = state;

  me_result_slot #(
    .SAD_WIDTH (SAD_WIDTH),
    .MVEC_W    (MVEC_W),
    .BLK_WIDTH (BLK_WIDTH)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (capture),
    .sad_in  (min_sad),
    .mvec_in (min_mvec),
    .idx_in  (blk_idx),
    .last_in (is_last),
    .ready   (res_ready),
    .valid   (res_valid),
    .sad     (res_sad),
    .mvec    (res_mvec),
    .idx     (res_idx),
    .last    (res_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      threshold <= '0;
      blk_idx   <= '0;
      num_q     <= '0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            num_q     <= num_blocks;
            threshold <= thr_cfg;
            err       <= 1'b0;
            blk_idx   <= '0;
            to_cnt    <= '0;
            if (num_blocks == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              req   <= 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (ack) begin
            req   <= 1'b0;
            state <= ST_RELEASE;
          end else begin
            // Timeout only flags; req stays high so the core is never abandoned.
            if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST)  err    <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!ack) begin
            if (is_last) begin
              state <= ST_DRAIN;
            end else if (slot_free) begin
              blk_idx <= blk_idx + BLK_WIDTH'(1);
              req     <= 1'b1;
              to_cnt  <= '0;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_DRAIN: begin
          // The last result may already have been taken while ack was falling.
          if (slot_free) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_req_initiator.sv
// Self-checking bench for me_req_initiator: a behavioural ME core answers req,
// every captured result is predicted into a queue and matched on acceptance.
module tb_me_req_initiator;

  localparam int SAD_W  = 16;
  localparam int BLK_W  = 12;
  localparam int MVEC_W = 12;
  localparam int TO     = 16;
  localparam int EXP_W  = BLK_W + 1 + SAD_W + MVEC_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BLK_W-1:0]  num_blocks;
  logic [SAD_W-1:0]  thr_cfg;
  logic              req;
  logic [SAD_W-1:0]  threshold;
  logic [BLK_W-1:0]  blk_idx;
  logic              ack = 1'b0;
  logic [SAD_W-1:0]  min_sad = '0;
  logic [MVEC_W-1:0] min_mvec = '0;
  logic              res_valid;
  logic              res_ready;
  logic [SAD_W-1:0]  res_sad;
  logic [MVEC_W-1:0] res_mvec;
  logic [BLK_W-1:0]  res_idx;
  logic              res_last;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        state_dbg;

  me_req_initiator #(
    .SAD_WIDTH(SAD_W), .SW_LENGTH(64), .BLK_WIDTH(BLK_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks),
    .thr_cfg(thr_cfg), .req(req), .threshold(threshold), .blk_idx(blk_idx),
    .ack(ack), .min_sad(min_sad), .min_mvec(min_mvec), .res_valid(res_valid),
    .res_ready(res_ready), .res_sad(res_sad), .res_mvec(res_mvec),
    .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural ME core ----------------
  int frame_n = 0, frame_thr = 0, frame_id = 0;
  int frame_k = 0, seen_id = 0, ack_wait = 0, ack_delay = 3;
  bit hold_ack = 0, rand_delay = 0, req_seen = 0;
  logic [EXP_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (seen_id != frame_id) begin
      seen_id = frame_id;
      frame_k = 0;
    end
    if (!rst_n) begin
      ack = 1'b0;
      ack_wait = 0;
      req_seen = 0;
    end else if (req && !ack) begin
      if (!req_seen) begin
        req_seen = 1;
        check("req_in_plan", frame_k < frame_n, 1);
        check("blk_idx", blk_idx, frame_k);
        check("threshold", threshold, frame_thr);
      end
      if (!hold_ack && ack_wait >= ack_delay) begin
        ack      = 1'b1;
        min_sad  = SAD_W'($urandom);
        min_mvec = MVEC_W'($urandom);
        exp_q.push_back({BLK_W'(frame_k), frame_k == frame_n - 1, min_sad, min_mvec});
        frame_k++;
        ack_wait = 0;
        req_seen = 0;
        if (rand_delay) ack_delay = $urandom_range(0, 6);
      end else begin
        ack_wait++;
      end
    end else if (!req && ack) begin
      ack = 1'b0;
    end
  end

  // ---------------- downstream ready ----------------
  bit ready_rand = 0, ready_fixed = 1, ready_rnd = 1;
  always @(negedge clk) ready_rnd = ($urandom_range(0, 3) != 0);
  always_comb res_ready = ready_rand ? ready_rnd : ready_fixed;

  // ---------------- result scoreboard (samples 1 ns after negedge) ----------------
  int acc_cnt = 0, done_cnt = 0;
  bit last_acc = 0, req_q = 0, gate_ok_q = 1, hold_q = 0;
  logic [SAD_W-1:0] sad_q;
  logic [EXP_W-1:0] mon_e;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (req && !req_q) check("issue_gate", gate_ok_q, 1);
      if (hold_q) check("res_hold", res_sad, sad_q);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {res_idx, res_last, res_sad, res_mvec}, mon_e);
        end
        acc_cnt++;
        last_acc = res_last;
      end
      if (done) done_cnt++;
      req_q     = req;
      gate_ok_q = !res_valid || res_ready;
      hold_q    = res_valid && !res_ready;
      sad_q     = res_sad;
    end else begin
      req_q = 0;
      gate_ok_q = 1;
      hold_q = 0;
    end
  end

  // ---------------- driver tasks ----------------
  int acc0 = 0, d0 = 0;

  task automatic start_frame(input int n, input int thr);
    @(negedge clk);
    num_blocks = BLK_W'(n);
    thr_cfg    = SAD_W'(thr);
    frame_n    = n;
    frame_thr  = thr;
    frame_id++;
    acc0  = acc_cnt;
    d0    = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", i < budget, 1);
    check("busy_with_done", busy, 0);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("result_count", acc_cnt - acc0, n);
    check("req_pulses", frame_k, n);
    check("last_accepted", last_acc, 1);
    check("exp_empty", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  logic [EXP_W-1:0] t3_e;
  logic [SAD_W-1:0] t3_sad;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_blocks = '0;
    thr_cfg = '0;
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_threshold", threshold, 0);
    check("rst_blk_idx", blk_idx, 0);
    check("rst_res", {res_valid, res_sad, res_mvec, res_idx, res_last}, 0);
    check("rst_flags", {busy, done, err}, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;

    // T1: three blocks, slow core (ack after 20 cycles exceeds the 16-cycle timeout)
    ack_delay = 20;
    start_frame(3, 100);
    check("t1_busy", busy, 1);
    check("t1_req", req, 1);
    finish_frame(3, 400);
    check("t1_err_slow_core", err, 1);

    // T2: empty frame
    start_frame(0, 5);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_req", req, 0);
    @(negedge clk);
    check("t2_done_pulse", done, 0);
    check("t2_err_cleared", err, 0);
    repeat (4) @(negedge clk);
    check("t2_done_once", done_cnt - d0, 1);

    // T3: downstream stalls after block 0
    ack_delay = 4;
    ready_fixed = 0;
    start_frame(2, 777);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("t3_valid", res_valid, 1);
    t3_e = exp_q[0];
    t3_sad = res_sad;
    check("t3_sad", t3_sad, t3_e[SAD_W+MVEC_W-1:MVEC_W]);
    repeat (50) @(negedge clk);
    check("t3_req_held_low", req, 0);
    check("t3_blk_idx", blk_idx, 0);
    check("t3_still_valid", res_valid, 1);
    check("t3_sad_held", res_sad, t3_sad);
    ready_fixed = 1;
    finish_frame(2, 200);

    // T4: core never acks -> timeout, then a late ack completes the frame
    ack_delay = 2;
    hold_ack = 1;
    start_frame(1, 9);
    check("t4_err_start", err, 0);
    repeat (15) @(negedge clk);
    check("t4_err_before", err, 0);
    @(negedge clk);
    check("t4_err_at_limit", err, 1);
    check("t4_req_kept", req, 1);
    repeat (10) @(negedge clk);
    check("t4_req_still", req, 1);
    hold_ack = 0;
    finish_frame(1, 100);
    check("t4_err_sticky", err, 1);
    start_frame(1, 10);
    check("t4_err_cleared", err, 0);
    finish_frame(1, 100);

    // T5: asynchronous reset mid-ISSUE
    hold_ack = 1;
    start_frame(3, 50);
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_req", req, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    hold_ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(2, 60);
    finish_frame(2, 300);

    // T6: start while busy is ignored
    ack_delay = 3;
    start_frame(4, 200);
    repeat (3) @(negedge clk);
    num_blocks = BLK_W'(9);
    thr_cfg = SAD_W'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t6_threshold", threshold, 200);
    finish_frame(4, 400);

    // Randomised frames: random sizes, core latency and downstream stalls
    ready_rand = 1;
    rand_delay = 1;
    for (int f = 0; f < 10; f++) begin
      start_frame($urandom_range(1, 6), $urandom_range(0, 65535));
      finish_frame(frame_n, 800);
    end
    ready_rand = 0;
    rand_delay = 0;

    // Minimum-latency core with a downstream that is always ready
    ack_delay = 0;
    start_frame(5, 1);
    finish_frame(5, 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
